// File: rtl/dco_frac_gen.sv
// dco_frac_gen: clock divider DCO with priority/linear half-period codes,
// fractional dither accumulator and glitch-free shadow code loading.
module dco_frac_gen #(
   parameter int CODE_W   = 8,
   parameter int CNT_W    = 8,
   parameter int FRAC_W   = 4,
   parameter int MIN_HALF = 2,
   parameter int DEF_HALF = 50
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ena,
   input  logic              code_load,
   input  logic              mode_in,
   input  logic [CODE_W-1:0] code_in,
   input  logic [FRAC_W-1:0] frac_in,
   output logic              code_busy,
   output logic              dco_out,
   output logic              tick,
   output logic [CNT_W-1:0]  half_out
);

   localparam int HMAX = (1 << CNT_W) - 2;

   generate
      if ((CODE_W + 2 > HMAX) || (DEF_HALF > HMAX) ||
          (MIN_HALF < 1) || (MIN_HALF > HMAX)) begin : g_bad_param
         $error("dco_frac_gen: illegal parameter combination");
      end
   endgenerate

   // active code, used for the half-period in progress
   logic              r_mode;
   logic [CODE_W-1:0] r_code;
   logic [FRAC_W-1:0] r_frac;

   // shadow (pending) code
   logic              r_pv;
   logic              r_pmode;
   logic [CODE_W-1:0] r_pcode;
   logic [FRAC_W-1:0] r_pfrac;

   logic [CNT_W-1:0]  r_cnt;
   logic              r_dco;
   logic              r_tick;
   logic [FRAC_W-1:0] r_acc;
   logic              r_c;

   logic [CNT_W-1:0]  w_h_pri;
   logic [CNT_W-1:0]  w_h_lin;
   logic [CNT_W-1:0]  w_h;
   logic [CNT_W-1:0]  w_heff;
   logic [31:0]       w_code_ext;
   logic              w_tog;
   logic [FRAC_W-1:0] w_nfrac;
   logic [FRAC_W:0]   w_sum;

   // half-period from the active code: leading-one index or clamped value
   always_comb begin
      w_h_pri = CNT_W'(DEF_HALF);
      for (int i = 0; i < CODE_W; i++) begin
         if (r_code[i]) w_h_pri = CNT_W'(i + 3);
      end
      w_code_ext = 32'(r_code);
      if (w_code_ext < 32'(MIN_HALF))
         w_h_lin = CNT_W'(MIN_HALF);
      else if (w_code_ext > 32'(HMAX))
         w_h_lin = CNT_W'(HMAX);
      else
         w_h_lin = w_code_ext[CNT_W-1:0];
      w_h = r_mode ? w_h_lin : w_h_pri;
   end

   // effective length, toggle condition and the dither add for the next half
   always_comb begin
      w_heff  = w_h + CNT_W'(r_c);
      w_tog   = ena && (r_cnt == (w_heff - CNT_W'(1)));
      // the frac that governs the half starting at this toggle
      w_nfrac = r_pv ? r_pfrac : r_frac;
      w_sum   = {1'b0, r_acc} + {1'b0, w_nfrac};
   end

   // half-period counter, output square wave and toggle pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_dco  <= 1'b0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= w_tog;
         if (w_tog) begin
            r_cnt <= '0;
            r_dco <= ~r_dco;
         end else if (ena) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   // dither accumulator; its carry lengthens the next half-period by one
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
         r_c   <= 1'b0;
      end else if (w_tog) begin
         r_acc <= w_sum[FRAC_W-1:0];
         r_c   <= w_sum[FRAC_W];
      end
   end

   // shadow capture and transfer to the active code only at a toggle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode  <= 1'b0;
         r_code  <= '0;
         r_frac  <= '0;
         r_pv    <= 1'b0;
         r_pmode <= 1'b0;
         r_pcode <= '0;
         r_pfrac <= '0;
      end else if (ena) begin
         if (w_tog) begin
            r_pv <= 1'b0;
            if (r_pv) begin
               r_mode <= r_pmode;
               r_code <= r_pcode;
               r_frac <= r_pfrac;
            end
         end
         // a load in the toggle cycle becomes the next pending code
         if (code_load) begin
            r_pv    <= 1'b1;
            r_pmode <= mode_in;
            r_pcode <= code_in;
            r_pfrac <= frac_in;
         end
      end
   end

   assign code_busy = r_pv;
   assign dco_out   = r_dco;
   assign tick      = r_tick;
   assign half_out  = w_heff;

endmodule

// File: tb/tb_dco_frac_gen.sv
// tb_dco_frac_gen: scoreboard bench for dco_frac_gen; expected half-period
// lengths are queued when stimulus is driven and popped at each tick.
module tb_dco_frac_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       code_load = 1'b0;
   logic       mode_in = 1'b0;
   logic [7:0] code_in = '0;
   logic [3:0] frac_in = '0;
   logic       code_busy;
   logic       dco_out;
   logic       tick;
   logic [7:0] half_out;

   int total = 0;
   int bad = 0;
   int since = 0;
   int exp_q[$];
   int m_h = 50;
   int m_c = 0;
   int m_acc = 0;
   int m_f = 0;
   int m_dco = 0;

   dco_frac_gen dut (
      .clk(clk), .rst_n(rst_n), .ena(ena),
      .code_load(code_load), .mode_in(mode_in),
      .code_in(code_in), .frac_in(frac_in),
      .code_busy(code_busy), .dco_out(dco_out),
      .tick(tick), .half_out(half_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      since++;
   endtask

   task automatic wait_tick(output int n);
      int g;
      g = 0;
      do begin
         step();
         g++;
      end while (!tick && g < 1000);
      if (!tick) check("tick_timeout", g, -1);
      n = since;
      since = 0;
   endtask

   task automatic ld(input logic m, input logic [7:0] c,
                     input logic [3:0] f);
      mode_in = m;
      code_in = c;
      frac_in = f;
      code_load = 1'b1;
      step();
      code_load = 1'b0;
      check("busy_set", code_busy, 1);
   endtask

   // reference: one toggle of the dither accumulator
   task automatic model_tog(input bit apply, input int h, input int f);
      int s;
      if (apply) begin
         m_h = h;
         m_f = f;
      end
      s = m_acc + m_f;
      m_c = s >> 4;
      m_acc = s & 15;
   endtask

   task automatic seg(input bit do_ld, input bit apply, input logic m,
                      input logic [7:0] c, input logic [3:0] f,
                      input int h, input int n);
      int got;
      if (do_ld) ld(m, c, f);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back(m_h + m_c);
         model_tog(apply && i == 0, h, int'(f));
      end
      for (int i = 0; i < n; i++) begin
         wait_tick(got);
         m_dco ^= 1;
         check("dco", dco_out, m_dco);
         if (exp_q.size() == 0) check("sb_empty", 0, 1);
         else check("half", got, exp_q.pop_front());
         if (i == 0) check("busy_clr", code_busy, 0);
         if (exp_q.size() > 0) check("half_out", half_out, exp_q[0]);
      end
   endtask

   initial begin
      int got;
      repeat (3) @(posedge clk);
      #1;
      check("rst_dco", dco_out, 0);
      check("rst_busy", code_busy, 0);
      check("rst_tick", tick, 0);
      check("rst_half", half_out, 50);
      rst_n = 1'b1;
      since = 0;

      seg(0, 0, 0, 8'h00, 4'd0, 0, 2);
      seg(1, 1, 0, 8'h80, 4'd0, 10, 3);
      seg(1, 1, 0, 8'h01, 4'd0, 3, 3);
      seg(1, 1, 0, 8'h00, 4'd0, 50, 2);
      seg(1, 1, 1, 8'h01, 4'd0, 2, 3);
      seg(1, 1, 1, 8'h0C, 4'd0, 12, 2);
      seg(1, 1, 1, 8'hFF, 4'd0, 254, 2);
      seg(1, 1, 1, 8'd10, 4'd8, 10, 5);
      seg(1, 1, 1, 8'd10, 4'd15, 10, 17);
      seg(1, 1, 1, 8'd9, 4'd0, 9, 2);

      // two loads while busy: last one wins
      ld(1, 8'd5, 4'd0);
      seg(1, 1, 1, 8'd7, 4'd0, 7, 3);

      // load in the toggle cycle applies at the following toggle
      repeat (6) step();
      mode_in = 1'b1;
      code_in = 8'd4;
      frac_in = 4'd0;
      code_load = 1'b1;
      step();
      code_load = 1'b0;
      check("tick_coinc", tick, 1);
      check("busy_coinc", code_busy, 1);
      check("half_coinc", since, m_h + m_c);
      m_dco ^= 1;
      check("dco_coinc", dco_out, m_dco);
      model_tog(0, 0, 0);
      since = 0;
      seg(0, 1, 1, 8'd4, 4'd0, 4, 3);

      // freeze for 4 cycles inside an H=6 half-period
      seg(1, 1, 1, 8'd6, 4'd0, 6, 2);
      step();
      step();
      ena = 1'b0;
      repeat (4) step();
      check("frz_tick", tick, 0);
      check("frz_dco", dco_out, m_dco);
      ena = 1'b1;
      wait_tick(got);
      check("frz_half", got, m_h + m_c + 4);
      m_dco ^= 1;
      model_tog(0, 0, 0);

      // async reset in the high phase with a code pending
      if (m_dco == 0) seg(0, 0, 0, 8'h00, 4'd0, 0, 1);
      ld(1, 8'd30, 4'd0);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_dco", dco_out, 0);
      check("arst_busy", code_busy, 0);
      check("arst_half", half_out, 50);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      since = 0;
      m_h = 50;
      m_c = 0;
      m_acc = 0;
      m_f = 0;
      m_dco = 0;
      exp_q.delete();
      seg(0, 0, 0, 8'h00, 4'd0, 0, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
